// File: rtl/bulls_cows_scorer.sv
// ---------------------------------------------------------------------------
// bulls_cows_scorer
//   Scores one guess against a secret for the xAyB (bulls-and-cows) game.
//   A start request in IDLE latches both codes. The scan then walks one digit
//   per cycle from the most significant digit down, counting exact matches (A)
//   and misplaced matches (B). It also flags illegal guesses: a digit above
//   MAX_DIGIT, or (when CHECK_DUP=1) a repeated digit. Results are published
//   with a one-cycle done pulse and held until the next accepted start.
//
// Ports
//   clk      in   1                 system clock, rising edge
//   rst_n    in   1                 asynchronous active-low reset
//   start    in   1                 request, only honoured in IDLE
//   secret   in   N_DIGITS*DIGIT_W  digit i at [i*DIGIT_W +: DIGIT_W], top = MSD
//   guess    in   N_DIGITS*DIGIT_W  same packing as secret
//   busy     out  1                 high while scanning or finishing
//   done     out  1                 one-cycle pulse, results valid
//   num_a    out  CW                exact-position matches
//   num_b    out  CW                right digit, wrong position
//   win      out  1                 all digits exact and guess legal
//   invalid  out  1                 guess broke a digit rule
// ---------------------------------------------------------------------------
module bulls_cows_scorer #(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9,
  parameter int CHECK_DUP = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [N_DIGITS*DIGIT_W-1:0]         secret,
  input  logic [N_DIGITS*DIGIT_W-1:0]         guess,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(N_DIGITS+1)-1:0]       num_a,
  output logic [$clog2(N_DIGITS+1)-1:0]       num_b,
  output logic                                win,
  output logic                                invalid
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = N_DIGITS * DIGIT_W;
  localparam logic [IW-1:0] IDX_MSD = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_q,   state_d;
  logic [IW-1:0]   idx_q,     idx_d;
  logic [DW-1:0]   secret_q,  secret_d;
  logic [DW-1:0]   guess_q,   guess_d;
  logic [CW-1:0]   num_a_q,   num_a_d;
  logic [CW-1:0]   num_b_q,   num_b_d;
  logic            invalid_q, invalid_d;
  logic            win_q,     win_d;
  logic            done_q,    done_d;

  // -------------------------------------------------------------------------
  // Per-digit views of the latched operands and the match vectors for the
  // digit currently under the scan pointer.
  // -------------------------------------------------------------------------
  logic [DIGIT_W-1:0]  secret_dig [N_DIGITS];
  logic [DIGIT_W-1:0]  guess_dig  [N_DIGITS];
  logic [DIGIT_W-1:0]  cur_s;
  logic [DIGIT_W-1:0]  cur_g;
  logic [N_DIGITS-1:0] s_in_other;   // current secret digit appears at another guess position
  logic [N_DIGITS-1:0] g_dup_lower;  // current guess digit repeats at a lower position

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign secret_dig[gi]  = secret_q[gi*DIGIT_W +: DIGIT_W];
      assign guess_dig[gi]   = guess_q[gi*DIGIT_W +: DIGIT_W];
      assign s_in_other[gi]  = (guess_dig[gi] == cur_s) && (IW'(gi) != idx_q);
      // Only lower positions are compared, so each repeated pair is caught
      // exactly once, when the higher of the two is scanned.
      assign g_dup_lower[gi] = (guess_dig[gi] == cur_g) && (IW'(gi) < idx_q);
    end
  endgenerate

  assign cur_s = secret_dig[idx_q];
  assign cur_g = guess_dig[idx_q];

  logic digit_range_bad;
  logic digit_dup_bad;

  // Zero-extend to 32 bits so MAX_DIGIT is never truncated to DIGIT_W.
  assign digit_range_bad = (32'(cur_g) > MAX_DIGIT);
  assign digit_dup_bad   = (CHECK_DUP != 0) && (|g_dup_lower);

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    num_a_d   = num_a_q;
    num_b_d   = num_b_q;
    invalid_d = invalid_q;
    win_d     = win_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          secret_d  = secret;
          guess_d   = guess;
          num_a_d   = '0;
          num_b_d   = '0;
          invalid_d = 1'b0;
          win_d     = 1'b0;
          idx_d     = IDX_MSD;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // An exact hit takes priority so a digit is never counted as both A and B.
        if (cur_s == cur_g) begin
          num_a_d = num_a_q + CW'(1);
        end else if (|s_in_other) begin
          num_b_d = num_b_q + CW'(1);
        end
        invalid_d = invalid_q | digit_range_bad | digit_dup_bad;
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      ST_DONE: begin
        // Counts are final here; publish them together with the pulse.
        done_d  = 1'b1;
        win_d   = (num_a_q == CW'(N_DIGITS)) && !invalid_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      secret_q  <= '0;
      guess_q   <= '0;
      num_a_q   <= '0;
      num_b_q   <= '0;
      invalid_q <= 1'b0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      secret_q  <= secret_d;
      guess_q   <= guess_d;
      num_a_q   <= num_a_d;
      num_b_q   <= num_b_d;
      invalid_q <= invalid_d;
      win_q     <= win_d;
      done_q    <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign num_a   = num_a_q;
  assign num_b   = num_b_q;
  assign win     = win_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bulls_cows_scorer.sv
// ---------------------------------------------------------------------------
// tb_bulls_cows_scorer
//   Three scorers share clock and reset:
//     dut 0 : N_DIGITS=4, CHECK_DUP=1
//     dut 1 : N_DIGITS=4, CHECK_DUP=0
//     dut 2 : N_DIGITS=6, CHECK_DUP=1
//   Each accepted request pushes a model result (with the cycle its done pulse
//   is due) into that dut's queue; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_bulls_cows_scorer;

  typedef struct {
    int done_cyc;
    int a;
    int b;
    bit win;
    bit inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] sec0 = '0, gu0 = '0, sec1 = '0, gu1 = '0;
  logic [23:0] sec2 = '0, gu2 = '0;

  logic [2:0] busy_v, done_v, win_v, inv_v;
  logic [2:0] na_o [3];
  logic [2:0] nb_o [3];

  bulls_cows_scorer #(.N_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9), .CHECK_DUP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .secret(sec0), .guess(gu0),
    .busy(busy_v[0]), .done(done_v[0]), .num_a(na_o[0]), .num_b(nb_o[0]),
    .win(win_v[0]), .invalid(inv_v[0]));

  bulls_cows_scorer #(.N_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9), .CHECK_DUP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .secret(sec1), .guess(gu1),
    .busy(busy_v[1]), .done(done_v[1]), .num_a(na_o[1]), .num_b(nb_o[1]),
    .win(win_v[1]), .invalid(inv_v[1]));

  bulls_cows_scorer #(.N_DIGITS(6), .DIGIT_W(4), .MAX_DIGIT(9), .CHECK_DUP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .secret(sec2), .guess(gu2),
    .busy(busy_v[2]), .done(done_v[2]), .num_a(na_o[2]), .num_b(nb_o[2]),
    .win(win_v[2]), .invalid(inv_v[2]));

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [3][$];
  int   next_ok [3] = '{0, 0, 0};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference scorer: A = positional matches; B = non-A secret digits found
  // anywhere else in the guess; invalid = out-of-range or any repeated pair.
  function automatic exp_t model(input int n, input logic [31:0] s,
                                 input logic [31:0] g, input bit dup);
    exp_t r;
    int sd [8];
    int gd [8];
    r.done_cyc = 0;
    r.a = 0;
    r.b = 0;
    r.inv = 1'b0;
    for (int i = 0; i < n; i++) begin
      sd[i] = int'(s[i*4 +: 4]);
      gd[i] = int'(g[i*4 +: 4]);
    end
    for (int i = 0; i < n; i++) begin
      if (sd[i] == gd[i]) begin
        r.a++;
      end else begin
        bit found = 1'b0;
        for (int j = 0; j < n; j++)
          if (j != i && gd[j] == sd[i]) found = 1'b1;
        if (found) r.b++;
      end
      if (gd[i] > 9) r.inv = 1'b1;
      for (int j = i + 1; j < n; j++)
        if (dup && gd[i] == gd[j]) r.inv = 1'b1;
    end
    r.win = (r.a == n) && !r.inv;
    return r;
  endfunction

  // Call at a negedge: start is sampled on the following rising edge.
  task automatic issue(input int w, input logic [31:0] s, input logic [31:0] g);
    int   n;
    int   e;
    exp_t x;
    n = (w == 2) ? 6 : 4;
    e = cyc + 1;
    case (w)
      0: begin start0 = 1'b1; sec0 = s[15:0]; gu0 = g[15:0]; end
      1: begin start1 = 1'b1; sec1 = s[15:0]; gu1 = g[15:0]; end
      default: begin start2 = 1'b1; sec2 = s[23:0]; gu2 = g[23:0]; end
    endcase
    if (e >= next_ok[w]) begin
      x = model(n, s, g, w != 1);
      x.done_cyc = e + n + 1;
      sb_q[w].push_back(x);
      next_ok[w] = e + n + 2;
      $display("T%0d dut%0d start secret=%h guess=%h -> expect a=%0d b=%0d win=%0d inv=%0d at %0d",
               e, w, s, g, x.a, x.b, x.win, x.inv, x.done_cyc);
    end else begin
      $display("T%0d dut%0d start secret=%h guess=%h -> expect ignored", e, w, s, g);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int w = 0; w < 3; w++) begin
        if (done_v[w]) begin
          if (sb_q[w].size() == 0) begin
            check_val($sformatf("spurious_done%0d", w), 32'd1, 32'd0);
          end else begin
            exp_t x;
            x = sb_q[w].pop_front();
            $display("T%0d dut%0d done a=%0d b=%0d win=%0d inv=%0d", cyc, w,
                     na_o[w], nb_o[w], win_v[w], inv_v[w]);
            check_val($sformatf("done_cycle%0d", w), cyc,      x.done_cyc);
            check_val($sformatf("num_a%0d", w),      na_o[w],  x.a);
            check_val($sformatf("num_b%0d", w),      nb_o[w],  x.b);
            check_val($sformatf("win%0d", w),        win_v[w], x.win);
            check_val($sformatf("invalid%0d", w),    inv_v[w], x.inv);
          end
        end else if (sb_q[w].size() > 0 && cyc > sb_q[w][0].done_cyc) begin
          check_val($sformatf("done_missing%0d", w), 32'd0, 32'd1);
          void'(sb_q[w].pop_front());
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rs, rg;

    // Reset state
    wait_cycles(2);
    check_val("rst_busy",  busy_v, 3'b000);
    check_val("rst_done",  done_v, 3'b000);
    check_val("rst_win",   win_v,  3'b000);
    check_val("rst_inv",   inv_v,  3'b000);
    check_val("rst_num_a", na_o[0], 0);
    check_val("rst_num_b", nb_o[2], 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Exact win, then hold and win-drop on the next start
    issue(0, 32'h1234, 32'h1234);
    check_val("busy_scan", busy_v[0], 1'b1);
    wait_cycles(8);
    check_val("hold_num_a", na_o[0], 4);
    check_val("hold_win",   win_v[0], 1'b1);
    issue(0, 32'h1234, 32'h4321);
    check_val("win_drop",   win_v[0], 1'b0);
    wait_cycles(6);

    // Directed patterns
    issue(0, 32'h1234, 32'h1243); wait_cycles(6);
    issue(0, 32'h1234, 32'h1123); wait_cycles(6);
    issue(0, 32'h1234, 32'h12A4); wait_cycles(6);
    issue(0, 32'h1234, 32'h5678); wait_cycles(6);
    issue(1, 32'h1234, 32'h1123); wait_cycles(6);
    issue(1, 32'h1234, 32'h1234); wait_cycles(6);
    issue(2, 32'h123456, 32'h654321); wait_cycles(8);
    issue(2, 32'h123456, 32'h123456); wait_cycles(8);
    issue(2, 32'h123456, 32'h112345); wait_cycles(8);

    // Randomised patterns (guess digits may exceed the legal range)
    for (int k = 0; k < 6; k++) begin
      rs = '0;
      rg = '0;
      for (int d = 0; d < 4; d++) begin
        rs = {rs[27:0], 4'($urandom_range(9))};
        rg = {rg[27:0], 4'($urandom_range(11))};
      end
      issue(0, rs, rg);
      wait_cycles(6);
    end

    // Starts at relative edges 0, 2, 5, 6: only 0 and 6 are accepted
    issue(0, 32'h1234, 32'h1243);
    wait_cycles(1);
    issue(0, 32'h1234, 32'h5678);
    wait_cycles(2);
    issue(0, 32'h1234, 32'h9999);
    issue(0, 32'h1234, 32'h4321);
    wait_cycles(8);

    // Reset in the middle of a scan
    issue(0, 32'h1234, 32'h1234);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      sb_q[w].delete();
      next_ok[w] = 0;
    end
    #1;
    check_val("midrst_busy",  busy_v[0], 1'b0);
    check_val("midrst_done",  done_v[0], 1'b0);
    check_val("midrst_num_a", na_o[0], 0);
    check_val("midrst_num_b", nb_o[0], 0);
    check_val("midrst_win",   win_v[0], 1'b0);
    check_val("midrst_inv",   inv_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(8);

    // Accepted cleanly after reset
    issue(0, 32'h1234, 32'h4321);
    wait_cycles(12);

    for (int w = 0; w < 3; w++)
      check_val($sformatf("queue_empty%0d", w), sb_q[w].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
